// File: rtl/branch_update_ctrl_pkg.sv
// Shared definitions for the bimodal predictor update controller:
// FSM encodings, PC increment, init counter value and queue entry layout.
package branch_update_ctrl_pkg;

    localparam logic [0:0]  ST_INIT  = 1'b0;
    localparam logic [0:0]  ST_RUN   = 1'b1;

    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [1:0]  CTR_INIT = 2'b01;

    typedef struct packed {
        logic [31:0] target;
        logic        pred;
        logic [31:0] pc;
    } bq_entry_t;

    localparam int BQ_WIDTH = $bits(bq_entry_t);

    function automatic logic [31:0] redirect_of(
        input bq_entry_t e,
        input logic      taken
    );
        return taken ? e.target : e.pc + PC_INC;
    endfunction

endpackage

// File: rtl/branch_update_ctrl_queue.sv
// In-order queue of in-flight branches; flush discards every entry,
// including one pushed in the same cycle.
module branch_queue #(
    parameter int WIDTH      = 65,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_BITS:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full queue still accepts a push when the head leaves this cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/branch_update_ctrl.sv
// Pattern-table sequencer: init sweep after reset, then one update per
// retired branch with flush/redirect on mispredict.
module branch_update_ctrl
    import branch_update_ctrl_pkg::*;
#(
    parameter int TABLE_BITS  = 5,
    parameter int QDEPTH_BITS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_branch_valid,
    input  logic [31:0]            id_pc,
    input  logic                   id_prediction,
    input  logic [31:0]            id_target,
    input  logic                   mem_branch_valid,
    input  logic                   mem_taken,
    output logic                   ready,
    output logic                   upd_valid,
    output logic [TABLE_BITS-1:0]  upd_index,
    output logic                   upd_taken,
    output logic                   upd_init,
    output logic                   mispredict,
    output logic [31:0]            redirect_pc,
    output logic [QDEPTH_BITS:0]   q_count,
    output logic                   err_overflow,
    output logic                   err_underflow
);

    localparam logic [TABLE_BITS-1:0] SWEEP_LAST = '1;

    logic [0:0]            state;
    logic [TABLE_BITS-1:0] sweep;

    bq_entry_t             push_e;
    bq_entry_t             head_e;
    logic [BQ_WIDTH-1:0]   head_bits;
    logic                  q_full;
    logic                  q_empty;

    logic                  push_req;
    logic                  pop_req;
    logic                  pop_ok;
    logic                  mispred_now;

    // Pipeline traffic is only honoured once ready has been raised.
    assign push_req    = ready & id_branch_valid;
    assign pop_req     = ready & mem_branch_valid;
    assign pop_ok      = pop_req & ~q_empty;
    assign mispred_now = pop_ok & (head_e.pred != mem_taken);

    assign push_e.target = id_target;
    assign push_e.pred   = id_prediction;
    assign push_e.pc     = id_pc;
    assign head_e        = bq_entry_t'(head_bits);

    branch_queue #(
        .WIDTH      (BQ_WIDTH),
        .DEPTH_BITS (QDEPTH_BITS)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop_req),
        .flush (mispred_now),
        .din   (push_e),
        .head  (head_bits),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_INIT;
            sweep         <= '0;
            ready         <= 1'b0;
            upd_valid     <= 1'b0;
            upd_index     <= '0;
            upd_taken     <= 1'b0;
            upd_init      <= 1'b0;
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            upd_valid  <= 1'b0;
            upd_init   <= 1'b0;
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
            case (state)
                ST_INIT: begin
                    upd_valid <= 1'b1;
                    upd_init  <= 1'b1;
                    upd_index <= sweep;
                    sweep     <= sweep + 1'b1;
                    if (sweep == SWEEP_LAST) state <= ST_RUN;
                end
                ST_RUN: begin
                    ready <= 1'b1;
                    if (pop_ok) begin
                        upd_valid <= 1'b1;
                        upd_index <= head_e.pc[TABLE_BITS+1:2];
                        upd_taken <= mem_taken;
                    end
                    if (mispred_now) begin
                        mispredict  <= 1'b1;
                        redirect_pc <= redirect_of(head_e, mem_taken);
                    end
                    if (push_req && q_full && !pop_ok) err_overflow <= 1'b1;
                    if (pop_req && q_empty) err_underflow <= 1'b1;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Directed bench for branch_update_ctrl: init sweep, pop updates,
// mispredict redirect, queue over/underflow and mid-run reset.
module tb_branch_update_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_branch_valid;
    logic [31:0] id_pc;
    logic        id_prediction;
    logic [31:0] id_target;
    logic        mem_branch_valid;
    logic        mem_taken;
    logic        ready;
    logic        upd_valid;
    logic [4:0]  upd_index;
    logic        upd_taken;
    logic        upd_init;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [2:0]  q_count;
    logic        err_overflow;
    logic        err_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_update_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .id_branch_valid  (id_branch_valid),
        .id_pc            (id_pc),
        .id_prediction    (id_prediction),
        .id_target        (id_target),
        .mem_branch_valid (mem_branch_valid),
        .mem_taken        (mem_taken),
        .ready            (ready),
        .upd_valid        (upd_valid),
        .upd_index        (upd_index),
        .upd_taken        (upd_taken),
        .upd_init         (upd_init),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .q_count          (q_count),
        .err_overflow     (err_overflow),
        .err_underflow    (err_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_branch_valid  = 1'b0;
        id_pc            = '0;
        id_prediction    = 1'b0;
        id_target        = '0;
        mem_branch_valid = 1'b0;
        mem_taken        = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic pred,
                        input logic [31:0] tgt);
        id_branch_valid = 1'b1;
        id_pc           = pc;
        id_prediction   = pred;
        id_target       = tgt;
        tick();
        id_branch_valid = 1'b0;
    endtask

    task automatic sweep_and_release();
        for (int i = 0; i < 32; i++) begin
            tick();
            check("init_valid", 32'(upd_valid), 32'd1);
            check("init_flag", 32'(upd_init), 32'd1);
            check("init_index", 32'(upd_index), i);
            check("init_ready", 32'(ready), 32'd0);
        end
        tick();
        check("ready_rise", 32'(ready), 32'd1);
        check("post_init_valid", 32'(upd_valid), 32'd0);
    endtask

    int pulses;

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_upd_valid", 32'(upd_valid), 32'd0);
        check("rst_upd_index", 32'(upd_index), 32'd0);
        check("rst_mispredict", 32'(mispredict), 32'd0);
        check("rst_redirect", redirect_pc, 32'd0);
        check("rst_q_count", 32'(q_count), 32'd0);
        check("rst_err_ovf", 32'(err_overflow), 32'd0);
        check("rst_err_udf", 32'(err_underflow), 32'd0);

        reset = 1'b0;
        sweep_and_release();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_no_write", 32'(upd_valid), 32'd0);
        end

        // Correct prediction
        push(32'h100, 1'b1, 32'h140);
        check("cp_q_count_push", 32'(q_count), 32'd1);
        mem_branch_valid = 1'b1;
        mem_taken        = 1'b1;
        tick();
        idle_inputs();
        check("cp_upd_valid", 32'(upd_valid), 32'd1);
        check("cp_upd_index", 32'(upd_index), 32'h00);
        check("cp_upd_taken", 32'(upd_taken), 32'd1);
        check("cp_upd_init", 32'(upd_init), 32'd0);
        check("cp_mispredict", 32'(mispredict), 32'd0);
        check("cp_q_count", 32'(q_count), 32'd0);
        tick();
        check("cp_upd_pulse", 32'(upd_valid), 32'd0);

        // Not-taken mispredict with two younger branches
        push(32'h204, 1'b1, 32'h1F0);
        push(32'h300, 1'b0, 32'h340);
        push(32'h400, 1'b1, 32'h480);
        check("nt_q_count_3", 32'(q_count), 32'd3);
        mem_branch_valid = 1'b1;
        mem_taken        = 1'b0;
        tick();
        idle_inputs();
        check("nt_mispredict", 32'(mispredict), 32'd1);
        check("nt_redirect", redirect_pc, 32'h208);
        check("nt_upd_index", 32'(upd_index), 32'd1);
        check("nt_upd_taken", 32'(upd_taken), 32'd0);
        check("nt_q_count", 32'(q_count), 32'd0);
        tick();
        check("nt_mp_pulse", 32'(mispredict), 32'd0);

        // Taken mispredict while a younger branch is pushed
        push(32'h80, 1'b0, 32'hC0);
        mem_branch_valid = 1'b1;
        mem_taken        = 1'b1;
        id_branch_valid  = 1'b1;
        id_pc            = 32'h84;
        id_prediction    = 1'b0;
        id_target        = 32'h90;
        tick();
        idle_inputs();
        check("tk_mispredict", 32'(mispredict), 32'd1);
        check("tk_redirect", redirect_pc, 32'hC0);
        check("tk_upd_index", 32'(upd_index), 32'd0);
        check("tk_q_count", 32'(q_count), 32'd0);
        tick();
        check("tk_q_stays_0", 32'(q_count), 32'd0);

        // Overflow then drain past empty
        for (int k = 0; k < 5; k++)
            push(32'h1000 + 32'(4 * k), 1'b1, 32'h2000);
        check("ovf_q_count", 32'(q_count), 32'd4);
        check("ovf_flag", 32'(err_overflow), 32'd1);
        check("ovf_no_udf", 32'(err_underflow), 32'd0);
        pulses = 0;
        mem_branch_valid = 1'b1;
        mem_taken        = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (upd_valid) pulses++;
            if (k < 4) check("drain_index", 32'(upd_index), k);
            check("drain_no_mp", 32'(mispredict), 32'd0);
        end
        idle_inputs();
        tick();
        if (upd_valid) pulses++;
        check("drain_pulses", pulses, 32'd4);
        check("udf_flag", 32'(err_underflow), 32'd1);
        check("udf_q_count", 32'(q_count), 32'd0);
        check("ovf_sticky", 32'(err_overflow), 32'd1);

        // Reset with three in flight
        push(32'h500, 1'b1, 32'h600);
        push(32'h504, 1'b1, 32'h600);
        push(32'h508, 1'b1, 32'h600);
        check("mr_q_count_3", 32'(q_count), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_q_count", 32'(q_count), 32'd0);
        check("mr_ready", 32'(ready), 32'd0);
        check("mr_err_ovf", 32'(err_overflow), 32'd0);
        check("mr_err_udf", 32'(err_underflow), 32'd0);
        check("mr_upd_valid", 32'(upd_valid), 32'd0);
        // Traffic during the sweep must be ignored
        id_branch_valid  = 1'b1;
        id_pc            = 32'h700;
        mem_branch_valid = 1'b1;
        tick();
        check("mr_sweep_idx0", 32'(upd_index), 32'd0);
        check("mr_sweep_init", 32'(upd_init), 32'd1);
        tick();
        idle_inputs();
        check("mr_sweep_idx1", 32'(upd_index), 32'd1);
        check("init_no_push", 32'(q_count), 32'd0);
        check("init_no_udf", 32'(err_underflow), 32'd0);
        check("init_no_ovf", 32'(err_overflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
